// File: rtl/flash_stream_pkg.sv
// Shared widths, FSM state encoding and FIFO entry layout for the flash stream reader.
package flash_stream_pkg;
  localparam int FLASH_ADDR_W = 24;
  localparam int FLASH_WORD_W = 32;
  localparam int ADDR_STEP    = 4;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    ISSUE,
    WAIT_DONE,
    CAPTURE,
    STALL
  } state_e;

  typedef struct packed {
    logic                    last;
    logic [FLASH_WORD_W-1:0] data;
  } word_t;
endpackage

// File: rtl/stream_fifo_sync.sv
// Synchronous FIFO; head is read straight from the storage flops so it holds while not popped.
module stream_fifo_sync #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A push at full is legal only when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem_q[rd_q];
  assign count   = cnt_q;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (do_pop) rd_d = rd_q + 1'b1;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/flash_stream_reader.sv
// Sequences consecutive 32-bit flash reads for a (start, count) command and streams the
// returned words through a small FIFO, after a post-reset startup delay.
module flash_stream_reader
  import flash_stream_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int STARTUP_CYCLES = 64,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [FLASH_ADDR_W-1:0] cmd_addr,
  input  logic [CNT_W-1:0]        cmd_count,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FLASH_WORD_W-1:0] out_data,
  output logic                    out_last,
  output logic                    busy,
  output logic                    ctrl_start,
  output logic [FLASH_ADDR_W-1:0] ctrl_addr,
  input  logic                    ctrl_busy,
  input  logic [FLASH_WORD_W-1:0] ctrl_data
);
  localparam int CW   = $clog2(FIFO_DEPTH+1);
  localparam int SU_W = (STARTUP_CYCLES > 1) ? $clog2(STARTUP_CYCLES) : 1;

  state_e                  state_q, state_d;
  logic [SU_W-1:0]         su_cnt_q, su_cnt_d;
  logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]        rem_q, rem_d;

  logic    push, pop, full, empty, su_done, free_after;
  logic [CW-1:0] fifo_cnt;
  word_t   fifo_din, fifo_dout;
  logic    unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign su_done  = (su_cnt_q == SU_W'(STARTUP_CYCLES - 1));
  assign pop      = out_valid & out_ready;
  // After a capture push, a slot is still free unless the FIFO fills with no pop alongside.
  assign free_after = pop | (fifo_cnt < CW'(FIFO_DEPTH - 1));
  assign fifo_din = '{last: (rem_q == CNT_W'(1)), data: ctrl_data};

  always_comb begin
    state_d  = state_q;
    su_cnt_d = su_cnt_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    push     = 1'b0;
    unique case (state_q)
      INIT: begin
        // The controller is not reset with us; never leave while a stale read is in flight.
        if (!su_done)        su_cnt_d = su_cnt_q + 1'b1;
        else if (!ctrl_busy) state_d  = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          addr_d = {cmd_addr[FLASH_ADDR_W-1:2], 2'b00};
          rem_d  = cmd_count;
          if (cmd_count != '0) state_d = full ? STALL : ISSUE;
        end
      end
      ISSUE:     if (ctrl_busy)  state_d = WAIT_DONE;
      WAIT_DONE: if (!ctrl_busy) state_d = CAPTURE;
      CAPTURE: begin
        push   = 1'b1;
        rem_d  = rem_q - 1'b1;
        addr_d = addr_q + FLASH_ADDR_W'(ADDR_STEP);
        if (rem_q == CNT_W'(1)) state_d = IDLE;
        else                    state_d = free_after ? ISSUE : STALL;
      end
      STALL:     if (!full) state_d = ISSUE;
      default:   state_d = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT;
      su_cnt_q <= '0;
      addr_q   <= '0;
      rem_q    <= '0;
    end else begin
      state_q  <= state_d;
      su_cnt_q <= su_cnt_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != INIT) && (state_q != IDLE);
  assign ctrl_start = (state_q == ISSUE);
  assign ctrl_addr  = addr_q;
  assign out_valid  = ~empty;
  assign out_data   = fifo_dout.data;
  assign out_last   = fifo_dout.last;

  stream_fifo_sync #(
    .WIDTH($bits(word_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );
endmodule

// File: tb/tb_flash_stream_reader.sv
// Scoreboard bench: stimulus queues expected words/addresses, a negedge monitor checks them.
module tb_flash_stream_reader;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        cmd_valid = 0;
  logic        cmd_ready;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_count = '0;
  logic        out_valid;
  logic        out_ready = 1;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        ctrl_start;
  logic [23:0] ctrl_addr;
  logic        ctrl_busy;
  logic [31:0] ctrl_data;

  int tests = 0;
  int fails = 0;

  logic [32:0] exp_q[$];
  logic [23:0] adr_q[$];

  // Behavioural controller: no reset, returns a fixed-latency read.
  logic        mbusy = 0;
  logic        hold_busy = 0;
  logic [31:0] mdata = '0;
  logic [23:0] maddr = '0;
  int          mcnt = 0;
  int          m_lat = 3;
  int          issues = 0;

  assign ctrl_busy = mbusy | hold_busy;
  assign ctrl_data = mdata;

  always #5 clk = ~clk;

  flash_stream_reader #(.FIFO_DEPTH(4), .STARTUP_CYCLES(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .ctrl_start(ctrl_start), .ctrl_addr(ctrl_addr),
    .ctrl_busy(ctrl_busy), .ctrl_data(ctrl_data)
  );

  always @(posedge clk) begin
    if (mcnt != 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mbusy <= 1'b0;
        mdata <= (maddr == 24'h010000) ? 32'h464c457f : {8'hA5, maddr};
      end
    end else if (ctrl_start && !ctrl_busy) begin
      mbusy  <= 1'b1;
      maddr  <= ctrl_addr;
      mcnt   <= m_lat;
      issues <= issues + 1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) chk("out_unexpected", 64'(out_valid), 64'(0));
        else begin
          chk("out_head", 64'({out_last, out_data}), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (ctrl_start && !ctrl_busy) begin
        if (adr_q.size() == 0) chk("start_unexpected", 64'(ctrl_start), 64'(0));
        else chk("ctrl_addr", 64'(ctrl_addr), 64'(adr_q.pop_front()));
      end
    end
  end

  task automatic send_cmd(input logic [23:0] a, input logic [15:0] c);
    int n = 0;
    while (!cmd_ready && n < 500) begin @(posedge clk); #1; n++; end
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'(1));
    cmd_addr = a; cmd_count = c; cmd_valid = 1;
    @(posedge clk); #1;
    cmd_valid = 0;
    if (c != 0) chk("busy_after_accept", 64'(busy), 64'(1));
    else begin
      chk("zero_cnt_busy", 64'(busy), 64'(0));
      chk("zero_cnt_ready", 64'(cmd_ready), 64'(1));
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(!busy && cmd_ready && !out_valid && exp_q.size() == 0) && n < 1000) begin
      @(negedge clk); n++;
    end
    chk(name, 64'(n < 1000), 64'(1));
  endtask

  initial begin
    int base;
    int n;
    // Reset state and startup delay
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
    chk("rst_out", 64'({out_valid, out_last, out_data}), 64'(0));
    chk("rst_busy_start", 64'({busy, ctrl_start}), 64'(0));
    chk("rst_ctrl_addr", 64'(ctrl_addr), 64'(0));
    rst_n = 1;
    for (int i = 1; i <= 64; i++) begin
      @(posedge clk); #1;
      chk("startup_ready", 64'(cmd_ready), 64'(i == 64));
      chk("startup_no_start", 64'(ctrl_start), 64'(0));
    end

    // Controller busy at release holds INIT
    rst_n = 0; hold_busy = 1;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    repeat (80) @(posedge clk);
    #1;
    chk("hold_busy_init", 64'(cmd_ready), 64'(0));
    hold_busy = 0;
    @(posedge clk); #1;
    chk("busy_drop_idle", 64'(cmd_ready), 64'(1));

    // Single word, busy falls with the capture
    exp_q.push_back({1'b1, 32'h464c457f});
    adr_q.push_back(24'h010000);
    send_cmd(24'h010000, 16'd1);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    chk("single_word_seen", 64'(out_valid), 64'(1));
    chk("single_busy_fell", 64'(busy), 64'(0));
    wait_idle("single_done");

    // Unaligned start, three words
    adr_q.push_back(24'h000000); adr_q.push_back(24'h000004); adr_q.push_back(24'h000008);
    exp_q.push_back({1'b0, 32'hA5000000});
    exp_q.push_back({1'b0, 32'hA5000004});
    exp_q.push_back({1'b1, 32'hA5000008});
    send_cmd(24'h000003, 16'd3);
    wait_idle("three_done");

    // Address wrap
    adr_q.push_back(24'hFFFFF8); adr_q.push_back(24'hFFFFFC);
    adr_q.push_back(24'h000000); adr_q.push_back(24'h000004);
    exp_q.push_back({1'b0, 32'hA5FFFFF8});
    exp_q.push_back({1'b0, 32'hA5FFFFFC});
    exp_q.push_back({1'b0, 32'hA5000000});
    exp_q.push_back({1'b1, 32'hA5000004});
    send_cmd(24'hFFFFF8, 16'd4);
    wait_idle("wrap_done");

    // Backpressure: FIFO fills after 4 reads, then stalls
    for (int i = 0; i < 6; i++) begin
      adr_q.push_back(24'h000100 + 24'(4 * i));
      exp_q.push_back({i == 5, 8'hA5, 24'h000100 + 24'(4 * i)});
    end
    out_ready = 0;
    base = issues;
    send_cmd(24'h000100, 16'd6);
    repeat (100) @(posedge clk);
    #1;
    chk("bp_issues", 64'(issues - base), 64'(4));
    chk("bp_no_start", 64'(ctrl_start), 64'(0));
    chk("bp_valid_busy", 64'({out_valid, busy}), 64'(2'b11));
    out_ready = 1;
    wait_idle("bp_done");
    chk("bp_issues_total", 64'(issues - base), 64'(6));

    // Reset in the middle of a read
    m_lat = 100;
    exp_q.push_back({1'b1, 32'hA5000200});
    adr_q.push_back(24'h000200);
    send_cmd(24'h000200, 16'd1);
    n = 0;
    while (!ctrl_busy && n < 50) begin @(posedge clk); #1; n++; end
    chk("midread_busy_seen", 64'(ctrl_busy), 64'(1));
    rst_n = 0;
    exp_q.delete();
    adr_q.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("midread_rst_out", 64'({out_valid, busy, cmd_ready, ctrl_start}), 64'(0));
    rst_n = 1;
    repeat (70) @(posedge clk);
    #1;
    chk("midread_wait_ctrl", 64'(cmd_ready), 64'(0));
    n = 0;
    while (ctrl_busy && n < 200) begin @(posedge clk); #1; n++; end
    chk("midread_ctrl_done", 64'(ctrl_busy), 64'(0));
    chk("midread_still_init", 64'(cmd_ready), 64'(0));
    @(posedge clk); #1;
    chk("midread_ready", 64'(cmd_ready), 64'(1));
    chk("midread_no_capture", 64'(out_valid), 64'(0));
    m_lat = 3;

    // Zero-length command
    base = issues;
    send_cmd(24'h000400, 16'd0);
    repeat (10) @(posedge clk);
    #1;
    chk("zero_cnt_no_issue", 64'(issues - base), 64'(0));
    chk("zero_cnt_idle", 64'({busy, cmd_ready, out_valid}), 64'(3'b010));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/flash_stream_reader.md
Name: flash_stream_reader

Overview:
Upstream sequencer for spi_w25q_read_32b. It accepts a (start address, word count) command and issues consecutive 32-bit reads to the controller using the controller's start/busy handshake. Returned words are buffered in a small FIFO and presented on a valid/ready stream for downstream consumers such as a bitstream or ELF loader. It also enforces a post-reset startup delay (flash tRES1) before the first read.

Parameters:
FIFO_DEPTH, 4, word FIFO depth; power of 2, at least 2.
STARTUP_CYCLES, 64, clk cycles to wait after reset release before any read (covers tRES1 = 3 us at the board clock).
CNT_W, 16, width of the word-count field.

Ports:
clk  in  1  system clock, the single clock domain
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  block can accept a command (IDLE only)
cmd_addr  in  24  byte address of the first word; bits [1:0] are ignored and treated as 0
cmd_count  in  CNT_W  number of 32-bit words to read
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts the head word
out_data  out  32  word exactly as returned by the controller, no byte swap
out_last  out  1  head word is the final word of its command
busy  out  1  high from command accept until the last word has been captured into the FIFO
ctrl_start  out  1  to controller start
ctrl_addr  out  24  to controller mem_addr
ctrl_busy  in  1  from controller busy
ctrl_data  in  32  from controller mem_data

Behaviour:
- Reset values: cmd_ready=0, out_valid=0, out_last=0, out_data=0, busy=0, ctrl_start=0, ctrl_addr=0. FIFO is emptied and all counters cleared.
- The controller has no reset. If reset is asserted mid-read, the block ignores the result of that read and stays in INIT until ctrl_busy=0 is sampled.
- FSM states: INIT, IDLE, ISSUE, WAIT_DONE, CAPTURE, STALL.
- INIT:
  - Counts STARTUP_CYCLES.
  - Exits to IDLE only when the count has expired and ctrl_busy=0.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch the address as {cmd_addr[23:2],2'b00} and latch remaining=cmd_count.
  - If cmd_count=0: accept the command, produce no words, busy stays 0, remain in IDLE.
  - Otherwise busy=1; go to ISSUE if the FIFO has a free slot, else STALL.
- ISSUE:
  - ctrl_start=1 and ctrl_addr=current address, held stable.
  - The first cycle with ctrl_busy=1 deasserts ctrl_start and moves to WAIT_DONE.
  - No timeout.
- WAIT_DONE: the first cycle with ctrl_busy=0 moves to CAPTURE.
- CAPTURE (1 cycle):
  - Push {last=(remaining==1), ctrl_data} into the FIFO.
  - remaining -= 1; address += 4, wrapping 24'hFFFFFC -> 24'h000000.
  - If remaining becomes 0: busy=0, go to IDLE.
  - Else go to ISSUE if a FIFO slot is free after this cycle's push/pop, otherwise STALL.
- STALL: wait until the FIFO is not full, then go to ISSUE.
- At most one read is outstanding at any time. A read is issued only with a free slot guaranteed, so a push never hits a full FIFO.
- FIFO:
  - Registered head; out_data and out_last are stable while out_valid=1 and out_ready=0.
  - Pop happens when out_valid & out_ready.
  - Simultaneous push and pop leaves occupancy unchanged and is legal at full.
  - Push into an empty FIFO makes out_valid=1 on the next cycle (1-cycle latency).
- A new command may be accepted while the FIFO still holds words from the previous command. Ordering is preserved; out_last delimits the commands.
- cmd_valid outside IDLE is ignored (no accept while cmd_ready=0).

Decomposition:
- Package flash_stream_pkg holds:
  - FLASH_ADDR_W=24 and FLASH_WORD_W=32.
  - FSM state enum {INIT, IDLE, ISSUE, WAIT_DONE, CAPTURE, STALL}.
  - ADDR_STEP=4.
- Sub-module stream_fifo_sync(WIDTH=33, DEPTH=FIFO_DEPTH): synchronous FIFO with push/pop/full/empty/count, asynchronous active-low reset.

Test Plan:
- Reset release with STARTUP_CYCLES=64 and a behavioural controller model -> cmd_ready rises exactly at cycle 64 and ctrl_start stays 0 until then. Asserting ctrl_busy=1 at release holds INIT until it drops.
- Command addr=24'h010000, count=1; model returns 32'h464c457f -> one out word 32'h464c457f with out_last=1, ctrl_addr=24'h010000, busy falls after CAPTURE.
- Command addr=24'h000003, count=3 with out_ready=1 -> ctrl_addr sequence 24'h000000, 24'h000004, 24'h000008; three words in order with out_last only on the third.
- Command addr=24'hFFFFF8, count=4, FIFO_DEPTH=4 -> addresses FFFFF8, FFFFFC, 000000, 000004 (wrap).
- out_ready=0 with count=6 -> exactly 4 reads issued, then STALL with no ctrl_start. Raising out_ready drains the FIFO and the remaining 2 reads issue, with the head stable throughout backpressure.
- rst_n pulsed while ctrl_busy=1 mid-read -> FIFO empty, out_valid=0, no capture of that read. Block waits for ctrl_busy=0 and STARTUP_CYCLES before cmd_ready=1. Separately, count=0 -> accepted, no ctrl_start, busy stays 0.
